carregador_instrucoes: RTL and testbench
========================================

# carregador_instrucoes

Instruction-memory loader: receives a program image as a byte stream (valid/ready handshake), assembles big-endian 32-bit words and writes them into the instruction memory's write port at consecutive addresses starting at `BASE_ADDR`. It sits between the boot byte source (UART receiver or testbench) and the instruction memory, holding the CPU (`busy`) until the image is loaded and its checksum verified.

## Interface
- `BASE_ADDR`, 1: address of the first instruction word written.
- `MAX_WORDS`, 150: largest accepted word count N.
- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; begins a load from IDLE, DONE or ERROR.
- `byte_in` in 8: stream byte.
- `byte_valid` in 1: `byte_in` is valid.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: instruction-memory write enable, one cycle per word.
- `mem_addr` out 32: write address; bits above the count are zero.
- `mem_data` out 32: assembled instruction word.
- `word_count` out 16: words written in the current load.
- `busy` out 1: load in progress (CPU held).
- `done` out 1: sticky, image loaded and checksum correct.
- `error` out 1: sticky, bad length or checksum mismatch.

## Operation
- Stream format: N high byte, N low byte, then 4·N data bytes (each word MSB first), then one checksum byte = sum of all 4·N data bytes mod 256.
- A byte is transferred only in a cycle with `byte_valid && byte_ready`; gaps in `byte_valid` are allowed anywhere.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERROR.
- IDLE: `start` → LEN_HI; clears `done`, `error`, `word_count`, checksum accumulator, byte index.
- LEN_HI: on transfer latch N[15:8] → LEN_LO.
- LEN_LO: on transfer latch N[7:0]; if N == 0 or N > `MAX_WORDS` → ERROR, else → DATA.
- DATA: on transfer shift byte into word register (first byte lands in [31:24]), add to checksum; after 4th byte → WRITE.
- WRITE: `mem_we`=1, `mem_addr`=`BASE_ADDR`+`word_count`, `mem_data`=assembled word; next cycle `word_count`+1; if new count == N → CHECK else → DATA.
- CHECK: on transfer compare byte with accumulator: equal → DONE (`done`=1), else → ERROR (`error`=1).
- DONE/ERROR: hold flags and `word_count`; `start` → LEN_HI (flags cleared).
- `start` in LEN_HI..CHECK is ignored.
- `byte_ready`=1 exactly in LEN_HI, LEN_LO, DATA, CHECK; `busy`=1 in LEN_HI through CHECK.
- Checksum accumulator 8-bit, wraps mod 256; length bytes are not summed.

## Timing
- Reset: state IDLE; `byte_ready`, `mem_we`, `busy`, `done`, `error` = 0; `mem_addr`, `mem_data`, `word_count` = 0.
- Reset asserted mid-load aborts immediately; no further `mem_we`; words already written are not undone.
- `start` in cycle t → `byte_ready`=1 and `busy`=1 in cycle t+1.
- 4th byte of a word transferred in cycle t → `mem_we`=1 in cycle t+1 only; `byte_ready`=0 in t+1; next byte accepted no earlier than t+2.
- Minimum load time with continuous `byte_valid`: 2 + 5·N + 1 cycles from first transfer to DONE.
- Checksum byte transferred in cycle t → `done` or `error` =1 and `busy`=0 in t+1.
- `mem_addr`/`mem_data` hold last written values outside WRITE.
- `start` and `reset` together: `reset` wins.

## Test plan
- N=1, bytes 00 01 80 00 00 4C CC → one write addr 1 data 0x8000004C; `done`=1, `word_count`=1.
- N=3 with `byte_valid` toggling every other cycle, correct checksum → writes at addr 1,2,3 with correct words, exactly 3 `mem_we` pulses, `done`=1.
- N=2 with checksum off by one → both words written, `error`=1, `done`=0; subsequent `start` clears `error`.
- Length 00 00 and length 00 97 (151) → ERROR right after LEN_LO, no `mem_we`, `byte_ready`=0.
- `start` pulsed during DATA → ignored, load completes normally.
- `reset` asserted after 2nd word written → next cycle all outputs at reset values, IDLE; fresh `start` reloads from addr 1.

Source files
------------

// File: rtl/carregador_instrucoes.sv
// carregador_instrucoes
// ---------------------------------------------------------------------------
// Instruction-memory boot loader. It accepts a program image as a byte stream
// over a valid/ready handshake, packs every four bytes (MSB first) into a
// 32-bit instruction word and writes the words to consecutive instruction
// memory addresses starting at BASE_ADDR. The CPU is held (busy) until the
// whole image has been received and its trailing checksum byte verified.
//
// Stream layout: N[15:8], N[7:0], 4*N data bytes, checksum byte
//                (checksum = sum of the data bytes mod 256).
//
// Parameters:
//   BASE_ADDR   address of the first instruction word written
//   MAX_WORDS   largest accepted word count N
//
// Ports:
//   clock       single clock, rising edge
//   reset       synchronous, active-high
//   start       one-cycle pulse, starts a load from IDLE, DONE or ERROR
//   byte_in     stream byte
//   byte_valid  byte_in carries a valid byte
//   byte_ready  loader takes a byte this cycle
//   mem_we      instruction-memory write enable (one cycle per word)
//   mem_addr    instruction-memory write address
//   mem_data    assembled instruction word
//   word_count  words written during the current load
//   busy        load in progress
//   done        sticky, image loaded and checksum correct
//   error       sticky, bad length or checksum mismatch
// ---------------------------------------------------------------------------
module carregador_instrucoes #(
  parameter logic [31:0] BASE_ADDR = 32'd1,
  parameter int          MAX_WORDS = 150
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] word_count_q, word_count_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        xfer;
  logic [15:0] len_new;
  logic [31:0] word_new;
  logic [15:0] count_inc;

  // Handshake and status outputs depend only on the current state, so they
  // are glitch-free and never combinationally loop back through byte_valid.
  always_comb begin
    byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                 (state_q == S_DATA)   || (state_q == S_CHECK);
    busy       = byte_ready || (state_q == S_WRITE);
    mem_we     = (state_q == S_WRITE);
  end

  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign word_count = word_count_q;
  assign done       = done_q;
  assign error      = error_q;

  assign xfer      = byte_valid && byte_ready;
  assign len_new   = {len_q[15:8], byte_in};
  assign word_new  = {word_q[23:0], byte_in};
  assign count_inc = word_count_q + 16'd1;

  // Next-state logic. The write address and data registers are loaded when
  // the fourth byte of a word arrives, so they are already stable during the
  // WRITE cycle and simply keep the last written values afterwards.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_d       = word_q;
    byte_idx_d   = byte_idx_q;
    csum_d       = csum_q;
    word_count_d = word_count_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    done_d       = done_q;
    error_d      = error_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d      = S_LEN_HI;
          done_d       = 1'b0;
          error_d      = 1'b0;
          word_count_d = 16'd0;
          csum_d       = 8'd0;
          byte_idx_d   = 2'd0;
        end
      end

      S_LEN_HI: begin
        if (xfer) begin
          len_d   = {byte_in, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_new;
          if ((len_new == 16'd0) || (len_new > MAX_N)) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          word_d     = word_new;
          csum_d     = csum_q + byte_in;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d    = S_WRITE;
            mem_addr_d = BASE_ADDR + {16'd0, word_count_q};
            mem_data_d = word_new;
          end
        end
      end

      S_WRITE: begin
        word_count_d = count_inc;
        if (count_inc == len_q) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_DATA;
        end
      end

      S_CHECK: begin
        if (xfer) begin
          if (byte_in == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset takes priority over any start or byte transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= 16'd0;
      word_q       <= 32'd0;
      byte_idx_q   <= 2'd0;
      csum_q       <= 8'd0;
      word_count_q <= 16'd0;
      mem_addr_q   <= 32'd0;
      mem_data_q   <= 32'd0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_q       <= word_d;
      byte_idx_q   <= byte_idx_d;
      csum_q       <= csum_d;
      word_count_q <= word_count_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

endmodule

// File: tb/tb_carregador_instrucoes.sv
// tb_carregador_instrucoes
// ---------------------------------------------------------------------------
// Directed bench for the instruction loader. Expected memory writes are
// queued before each image is streamed; a monitor pops and compares them
// whenever the loader pulses mem_we. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_carregador_instrucoes;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic [15:0] word_count;
   logic        busy;
   logic        done;
   logic        error;

   int testsRun = 0;
   int testsFailed = 0;
   int writeCount = 0;
   int writesBefore;

   logic [63:0] expQueue [$];

   carregador_instrucoes #(
      .BASE_ADDR (32'd1),
      .MAX_WORDS (150)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   // Free-running 100 MHz clock
   always #5 clock = ~clock;

   // Single comparison point shared by the monitor and the directed checks
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: every write pulse must match the oldest queued expectation
   always @(negedge clock) begin
      if (mem_we === 1'b1) begin
         writeCount++;
         if (expQueue.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                     mem_addr, mem_data);
         end else begin
            logic [63:0] exp;
            exp = expQueue.pop_front();
            checkOutput("write_addr", mem_addr, exp[63:32]);
            checkOutput("write_data", mem_data, exp[31:0]);
         end
      end
   end

   task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data);
      expQueue.push_back({addr, data});
   endtask

   // Offers one byte (optionally after an idle gap) and waits, with a bound,
   // until the loader takes it. Called and returns on a falling edge.
   task automatic applyStimulus(input logic [7:0] b, input bit gap);
      int waitCycles;
      waitCycles = 0;
      if (gap) begin
         byte_valid = 1'b0;
         @(negedge clock);
      end
      byte_in    = b;
      byte_valid = 1'b1;
      while (byte_ready !== 1'b1 && waitCycles < 50) begin
         @(negedge clock);
         waitCycles++;
      end
      if (byte_ready !== 1'b1) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL byte_timeout: byte 0x%0h not accepted, ready=%b, expected 1",
                  b, byte_ready);
      end else begin
         @(negedge clock);
      end
      byte_valid = 1'b0;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic sendWord(input logic [31:0] w, input bit gap);
      applyStimulus(w[31:24], gap);
      applyStimulus(w[23:16], gap);
      applyStimulus(w[15:8],  gap);
      applyStimulus(w[7:0],   gap);
   endtask

   // Holds reset for a couple of cycles and releases it on a falling edge
   task automatic doReset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
      checkOutput({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
      checkOutput({tag, "_busy"},       {31'd0, busy},       32'd0);
      checkOutput({tag, "_done"},       {31'd0, done},       32'd0);
      checkOutput({tag, "_error"},      {31'd0, error},      32'd0);
      checkOutput({tag, "_mem_addr"},   mem_addr,            32'd0);
      checkOutput({tag, "_mem_data"},   mem_data,            32'd0);
      checkOutput({tag, "_word_count"}, {16'd0, word_count}, 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checkResetValues("reset");
      reset = 1'b0;
      @(negedge clock);

      // Single word image, also checks start latency and write timing
      $display("[TB] N=1 image");
      expectWrite(32'd1, 32'h8000004C);
      pulseStart();
      checkOutput("start_ready", {31'd0, byte_ready}, 32'd1);
      checkOutput("start_busy",  {31'd0, busy},       32'd1);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h80, 1'b0);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h4C, 1'b0);
      checkOutput("write_cycle_we",    {31'd0, mem_we},     32'd1);
      checkOutput("write_cycle_ready", {31'd0, byte_ready}, 32'd0);
      applyStimulus(8'hCC, 1'b0);
      checkOutput("n1_done",       {31'd0, done},       32'd1);
      checkOutput("n1_error",      {31'd0, error},      32'd0);
      checkOutput("n1_busy",       {31'd0, busy},       32'd0);
      checkOutput("n1_word_count", {16'd0, word_count}, 32'd1);
      @(negedge clock);
      checkOutput("n1_hold_addr", mem_addr, 32'd1);
      checkOutput("n1_hold_data", mem_data, 32'h8000004C);

      // Three words with byte_valid toggling every other cycle
      $display("[TB] N=3 image with gaps");
      writesBefore = writeCount;
      expectWrite(32'd1, 32'h11223344);
      expectWrite(32'd2, 32'hDEADBEEF);
      expectWrite(32'd3, 32'h00000001);
      pulseStart();
      checkOutput("n3_done_cleared", {31'd0, done}, 32'd0);
      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'h03, 1'b1);
      sendWord(32'h11223344, 1'b1);
      sendWord(32'hDEADBEEF, 1'b1);
      sendWord(32'h00000001, 1'b1);
      applyStimulus(8'hE3, 1'b1);
      checkOutput("n3_done",       {31'd0, done},                32'd1);
      checkOutput("n3_word_count", {16'd0, word_count},          32'd3);
      checkOutput("n3_writes",     32'(writeCount - writesBefore), 32'd3);

      // Two words with a checksum off by one
      $display("[TB] N=2 bad checksum");
      expectWrite(32'd1, 32'h01020304);
      expectWrite(32'd2, 32'hA0B0C0D0);
      pulseStart();
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h02, 1'b0);
      sendWord(32'h01020304, 1'b0);
      sendWord(32'hA0B0C0D0, 1'b0);
      applyStimulus(8'hEB, 1'b0);
      checkOutput("badsum_error",      {31'd0, error},      32'd1);
      checkOutput("badsum_done",       {31'd0, done},       32'd0);
      checkOutput("badsum_word_count", {16'd0, word_count}, 32'd2);
      pulseStart();
      checkOutput("restart_error_cleared", {31'd0, error}, 32'd0);
      checkOutput("restart_busy",          {31'd0, busy},  32'd1);

      // Zero length: rejected right after the low length byte
      $display("[TB] length boundaries");
      writesBefore = writeCount;
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h00, 1'b0);
      checkOutput("len0_error", {31'd0, error},      32'd1);
      checkOutput("len0_ready", {31'd0, byte_ready}, 32'd0);
      checkOutput("len0_busy",  {31'd0, busy},       32'd0);

      // One above the maximum
      pulseStart();
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h97, 1'b0);
      checkOutput("len151_error", {31'd0, error},      32'd1);
      checkOutput("len151_ready", {31'd0, byte_ready}, 32'd0);
      repeat (3) @(negedge clock);
      checkOutput("badlen_no_write", 32'(writeCount - writesBefore), 32'd0);

      // Exactly the maximum is accepted; abort with reset afterwards
      pulseStart();
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h96, 1'b0);
      checkOutput("len150_error", {31'd0, error},      32'd0);
      checkOutput("len150_ready", {31'd0, byte_ready}, 32'd1);
      doReset();

      // start during DATA must be ignored
      $display("[TB] start during DATA");
      expectWrite(32'd1, 32'hCAFEF00D);
      pulseStart();
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'hCA, 1'b0);
      applyStimulus(8'hFE, 1'b0);
      pulseStart();
      applyStimulus(8'hF0, 1'b0);
      applyStimulus(8'h0D, 1'b0);
      applyStimulus(8'hC5, 1'b0);
      checkOutput("ignstart_done",       {31'd0, done},       32'd1);
      checkOutput("ignstart_word_count", {16'd0, word_count}, 32'd1);

      // Reset after the second word of three has been written
      $display("[TB] reset mid-load");
      expectWrite(32'd1, 32'h00000010);
      expectWrite(32'd2, 32'h00000020);
      pulseStart();
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h03, 1'b0);
      sendWord(32'h00000010, 1'b0);
      sendWord(32'h00000020, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkResetValues("midreset");
      reset = 1'b0;
      @(negedge clock);
      expectWrite(32'd1, 32'h12345678);
      pulseStart();
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h01, 1'b0);
      sendWord(32'h12345678, 1'b0);
      applyStimulus(8'h14, 1'b0);
      checkOutput("reload_done",       {31'd0, done},       32'd1);
      checkOutput("reload_word_count", {16'd0, word_count}, 32'd1);

      repeat (2) @(negedge clock);
      checkOutput("queue_drained", 32'(expQueue.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
